// File: rtl/chunked_addsub.sv
// Multi-cycle adder/subtractor: one CHUNK-bit adder slice is reused over WIDTH/CHUNK cycles.
// Operands arrive and results leave through valid/ready handshakes.
module chunked_addsub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $fatal(1, "chunked_addsub: WIDTH must be a positive multiple of CHUNK");
  end

  localparam int unsigned NChunk = (CHUNK > 0) ? WIDTH / CHUNK : 1;
  localparam int unsigned IdxW   = (NChunk > 1) ? $clog2(NChunk) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NChunk - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry_q;
  logic [IdxW-1:0]  idx_q;
  logic             in_ready_q, out_valid_q, busy_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q;

  logic [CHUNK-1:0] a_slice, b_slice, r_slice;
  logic             c_slice;
  logic             carry_msb;
  logic [WIDTH-1:0] sum_d;

  // Select the active chunk with constant-index compares so every slice is a static select.
  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int k = 0; k < NChunk; k++) begin
      if (idx_q == IdxW'(k)) begin
        a_slice = a_q[k*CHUNK +: CHUNK];
        b_slice = b_q[k*CHUNK +: CHUNK];
      end
    end
    {c_slice, r_slice} = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry_q};
    // Carry into the slice MSB, recovered from its sum bit; only meaningful on the last chunk.
    carry_msb = a_slice[CHUNK-1] ^ b_slice[CHUNK-1] ^ r_slice[CHUNK-1];
    sum_d = sum_q;
    for (int k = 0; k < NChunk; k++) begin
      if (idx_q == IdxW'(k)) begin
        sum_d[k*CHUNK +: CHUNK] = r_slice;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            // Subtraction is a + ~b + ~cin, so the slice adder never changes mode.
            a_q        <= a;
            b_q        <= sub ? ~b : b;
            carry_q    <= sub ^ cin;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= StRun;
          end
        end
        StRun: begin
          sum_q   <= sum_d;
          carry_q <= c_slice;
          if (idx_q == LastIdx) begin
            cout_q      <= c_slice;
            ovf_q       <= carry_msb ^ c_slice;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_chunked_addsub.sv
// Directed and random bench for chunked_addsub; three instances (CHUNK 4/16/1) share stimulus.
module tb_chunked_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, cin, sub, out_ready;
  logic [15:0] a, b;
  logic        in_ready[3], out_valid[3], cout[3], ovf[3], busy[3];
  logic [15:0] sum[3];
  int          lat_exp[3] = '{4, 1, 16};

  int n_checks = 0;
  int n_pass   = 0;

  chunked_addsub #(.WIDTH(16), .CHUNK(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid[0]), .out_ready(out_ready), .sum(sum[0]),
    .cout(cout[0]), .ovf(ovf[0]), .busy(busy[0])
  );
  chunked_addsub #(.WIDTH(16), .CHUNK(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid[1]), .out_ready(out_ready), .sum(sum[1]),
    .cout(cout[1]), .ovf(ovf[1]), .busy(busy[1])
  );
  chunked_addsub #(.WIDTH(16), .CHUNK(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid[2]), .out_ready(out_ready), .sum(sum[2]),
    .cout(cout[2]), .ovf(ovf[2]), .busy(busy[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op to all instances, check latency and result, optionally stall in DONE for
  // `hold` cycles while in_valid keeps offering a junk operand.
  task automatic do_op(input string tag, input logic [15:0] op_a, input logic [15:0] op_b,
                       input logic op_c, input logic op_s, input logic [15:0] es,
                       input logic ec, input logic eo, input int hold);
    int got_lat[3];
    int cyc;
    bit all_done;
    got_lat = '{0, 0, 0};
    for (int i = 0; i < 3; i++) check($sformatf("%s idle_ready%0d", tag, i), in_ready[i], 1);
    a = op_a; b = op_b; cin = op_c; sub = op_s; in_valid = 1'b1;
    tick();
    if (hold > 0) begin
      a = 16'h1234;
    end else begin
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom);
    end
    cin = 1'($urandom); sub = 1'($urandom);
    cyc = 0;
    all_done = 1'b0;
    while (!all_done && cyc < 40) begin
      if (cyc > 0) tick();
      else tick();
      cyc++;
      check($sformatf("%s busy", tag), busy[0], 1);
      check($sformatf("%s run_ready", tag), in_ready[0], 0);
      all_done = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (got_lat[i] == 0 && out_valid[i]) got_lat[i] = cyc;
        if (got_lat[i] == 0) all_done = 1'b0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s lat%0d", tag, i), got_lat[i], lat_exp[i]);
      check($sformatf("%s sum%0d", tag, i), sum[i], es);
      check($sformatf("%s cout%0d", tag, i), cout[i], ec);
      check($sformatf("%s ovf%0d", tag, i), ovf[i], eo);
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      check($sformatf("%s hold_sum", tag), sum[0], es);
      check($sformatf("%s hold_cout", tag), cout[0], ec);
      check($sformatf("%s hold_ovf", tag), ovf[0], eo);
      check($sformatf("%s hold_valid", tag), out_valid[0], 1);
      check($sformatf("%s hold_ready", tag), in_ready[0], 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s rel_valid%0d", tag, i), out_valid[i], 0);
      check($sformatf("%s rel_ready%0d", tag, i), in_ready[i], 1);
    end
  endtask

  // Reference: plain integer arithmetic, independent of the chunked structure.
  task automatic model(input logic [15:0] x, input logic [15:0] y, input logic c, input logic s,
                       output logic [15:0] rs, output logic rc, output logic ro);
    logic [16:0] r;
    int sr;
    if (!s) begin
      r  = {1'b0, x} + {1'b0, y} + {16'b0, c};
      rc = r[16];
      sr = int'($signed(x)) + int'($signed(y)) + int'(c);
    end else begin
      r  = {1'b0, x} - {1'b0, y} - {16'b0, c};
      rc = ~r[16];
      sr = int'($signed(x)) - int'($signed(y)) - int'(c);
    end
    rs = r[15:0];
    ro = (sr > 32767) || (sr < -32768);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra, rb, es;
    logic rc, rs, ec, eo;
    bit spurious;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst in_ready%0d", i), in_ready[i], 1);
      check($sformatf("rst out_valid%0d", i), out_valid[i], 0);
      check($sformatf("rst busy%0d", i), busy[i], 0);
      check($sformatf("rst sum%0d", i), sum[i], 0);
      check($sformatf("rst cout%0d", i), cout[i], 0);
      check($sformatf("rst ovf%0d", i), ovf[i], 0);
    end

    do_op("add_carry8",  16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 0);
    do_op("add_wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    do_op("add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
    do_op("sub_neg",     16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
    do_op("sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0);
    do_op("sub_borrow",  16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0, 0);
    do_op("add_cin",     16'h1000, 16'h2FFF, 1'b1, 1'b0, 16'h4000, 1'b0, 1'b0, 0);
    do_op("backpress",   16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, 3);
    spurious = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out_valid[0] || busy[0]) spurious = 1'b1;
    end
    check("no_capture_in_run", spurious, 0);

    // Abort while the CHUNK=4 instance is working on chunk 2.
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst in_ready", in_ready[0], 1);
    check("midrst out_valid", out_valid[0], 0);
    check("midrst busy", busy[0], 0);
    check("midrst sum", sum[0], 0);
    check("midrst cout", cout[0], 0);
    spurious = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      for (int j = 0; j < 3; j++) if (out_valid[j]) spurious = 1'b1;
    end
    check("midrst no_result", spurious, 0);
    do_op("after_rst", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 0);

    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      if (n % 8 == 0) ra = 16'h8000 ^ 16'($urandom_range(0, 3));
      if (n % 8 == 1) rb = 16'h7FFF ^ 16'($urandom_range(0, 3));
      model(ra, rb, rc, rs, es, ec, eo);
      do_op($sformatf("rnd%0d", n), ra, rb, rc, rs, es, ec, eo, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
